// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and default operand/digit sizes.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_W = 16;
   localparam int DEFAULT_D = 5;

endpackage

// File: rtl/binary_to_bcd_seq_add3.sv
// Per-digit double-dabble correction: a nibble of 5 or more gets 3 added
// so that the following left shift carries cleanly into the next digit.
module bcd_add3 (
   input  logic [3:0] digit,
   output logic [3:0] corrected
);

   assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// W iterations per conversion, with a held result register and done pulse.
module binary_to_bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int W = DEFAULT_W,
   parameter int D = DEFAULT_D
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   bin,
   output logic           busy,
   output logic           done,
   output logic [4*D-1:0] bcd
);

   localparam int CW = $clog2(W + 1);
   localparam int SW = 4 * D + W;

   state_t        state;
   logic [CW-1:0] count;
   logic [SW-1:0] sreg;
   logic [4*D-1:0] corrected;
   logic [SW-1:0] pre_shift;
   logic [SW-1:0] shifted;

   // The BCD field sits above the binary field; each nibble is corrected
   // independently so no carry ever crosses a digit boundary.
   for (genvar g = 0; g < D; g++) begin : g_digit
      bcd_add3 u_add3 (
         .digit     (sreg[W + 4*g +: 4]),
         .corrected (corrected[4*g +: 4])
      );
   end

   assign pre_shift = {corrected, sreg[W-1:0]};
   assign shifted   = pre_shift << 1;

   // busy and done are registered alongside the state so they are clean
   // flop outputs rather than decodes of a multi-bit state vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         sreg  <= '0;
         bcd   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sreg  <= {{(4*D){1'b0}}, bin};
                  count <= '0;
                  state <= SHIFT;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            SHIFT: begin
               sreg  <= shifted;
               count <= count + 1'b1;
               if (count == CW'(W - 1)) begin
                  bcd   <= shifted[SW-1:W];
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Randomised and directed checks of binary_to_bcd_seq against a decimal
// reference model built from plain division and modulo.
module tb_binary_to_bcd_seq;
   import bin2bcd_pkg::*;

   localparam int W = DEFAULT_W;
   localparam int D = DEFAULT_D;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   bin;
   logic           busy;
   logic           done;
   logic [4*D-1:0] bcd;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   binary_to_bcd_seq #(.W(W), .D(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Decimal digits by repeated division, packed one digit per nibble.
   function automatic logic [31:0] ref_bcd(input int unsigned value);
      logic [31:0] r;
      int unsigned v;
      r = '0;
      v = value;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int bad_nibbles(input logic [4*D-1:0] b);
      int n;
      n = 0;
      for (int i = 0; i < D; i++)
         if (b[4*i +: 4] > 4'd9) n++;
      return n;
   endfunction

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (!done && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   // One full conversion; optionally re-pulses start mid-flight with a
   // different operand, and watches for stray done pulses afterwards.
   task automatic applyStimulus(input logic [W-1:0] value, input int poke_at, input int watch);
      int n;
      int busy_cycles;
      int extra;
      logic [31:0] expected;
      expected = ref_bcd(int'(value));
      @(negedge clk);
      start = 1'b1;
      bin   = value;
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = W'($urandom);
      n = 0;
      busy_cycles = 0;
      while (!done && n < 40) begin
         if (busy) busy_cycles++;
         if (n == poke_at) begin
            start = 1'b1;
            bin   = W'(777);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      if (busy) busy_cycles++;
      checkOutput($sformatf("latency(%0d)", value), 32'(n), 32'(W));
      checkOutput($sformatf("busy_len(%0d)", value), 32'(busy_cycles), 32'(W + 1));
      checkOutput($sformatf("bcd(%0d)", value), 32'(bcd), expected);
      checkOutput($sformatf("digits(%0d)", value), 32'(bad_nibbles(bcd)), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("done_pulse_width", {31'd0, done}, 32'd0);
      checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
      checkOutput("bcd_held", 32'(bcd), expected);
      extra = 0;
      for (int i = 0; i < watch; i++) begin
         @(posedge clk);
         #1;
         if (done) extra++;
      end
      if (watch > 0) checkOutput("no_second_done", 32'(extra), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t1;
      int t2;
      int waited;
      int extra;
      rst   = 1'b0;
      start = 1'b0;
      bin   = '0;
      #1;
      rst = 1'b1;
      #1;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_bcd", 32'(bcd), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] directed operands");
      applyStimulus(W'(0), -1, 0);
      applyStimulus(W'(65535), -1, 0);
      applyStimulus(W'(9999), -1, 0);
      applyStimulus(W'(49), -1, 0);
      applyStimulus(W'(10000), -1, 0);
      applyStimulus(W'(99), -1, 0);

      $display("[TB] start ignored while busy");
      applyStimulus(W'(1234), 5, 25);

      $display("[TB] reset mid-conversion");
      @(negedge clk);
      start = 1'b1;
      bin   = W'(5000);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_bcd", 32'(bcd), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (done) extra++;
      end
      checkOutput("abort_no_done", 32'(extra), 32'd0);
      checkOutput("abort_bcd_stays", 32'(bcd), 32'd0);
      applyStimulus(W'(4321), -1, 0);

      $display("[TB] back-to-back with start held");
      @(negedge clk);
      start = 1'b1;
      bin   = W'(100);
      @(posedge clk);
      #1;
      bin = W'(200);
      waitDone(waited);
      checkOutput("b2b_first_seen", {31'd0, done}, 32'd1);
      t1 = cyc;
      checkOutput("b2b_first_bcd", 32'(bcd), 32'h00100);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("b2b_bcd_held_in_flight", 32'(bcd), 32'h00100);
      checkOutput("b2b_busy_again", {31'd0, busy}, 32'd1);
      waitDone(waited);
      checkOutput("b2b_second_seen", {31'd0, done}, 32'd1);
      t2 = cyc;
      start = 1'b0;
      checkOutput("b2b_spacing", 32'(t2 - t1), 32'(W + 2));
      checkOutput("b2b_second_bcd", 32'(bcd), 32'h00200);
      repeat (3) @(posedge clk);

      $display("[TB] random operands");
      for (int i = 0; i < 150; i++)
         applyStimulus(W'($urandom_range(0, 65535)), -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 The module SHALL have parameter W, default 16, binary input width in bits.
REQ-002 The module SHALL have parameter D, default 5, number of BCD output digits; legal only if 10^D > 2^W - 1.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request to convert bin; sampled only in IDLE.
REQ-006 Port bin  input  W  unsigned binary operand; sampled on the accepting edge only.
REQ-007 Port busy  output  1  high while a conversion is in progress (SHIFT or DONE).
REQ-008 Port done  output  1  one-cycle pulse; bcd valid in that cycle.
REQ-009 Port bcd  output  4*D  packed BCD result; digit 0 in bits [3:0], most significant digit in the top nibble.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-011 IDLE with start=1 at edge k: load the shift register with {4*D zeros, bin} and clear the iteration counter; next state is SHIFT.
REQ-012 IDLE with start=0: remain in IDLE with all registers held.
REQ-013 SHIFT, one iteration per edge (double dabble): add 3 to every BCD nibble >= 5, then shift the whole register left by 1.
REQ-014 SHIFT SHALL run exactly W iterations (edges k+1..k+W); counter width is ceil(log2(W+1)).
REQ-015 Edge k+W: the corrected BCD nibbles SHALL be written to the bcd register; next state is DONE.
REQ-016 DONE (cycle after edge k+W): done=1, busy=1; next edge goes to IDLE unconditionally.
REQ-017 Latency: done SHALL be high in the cycle after edge k+W (16 cycles at default W).
REQ-018 Throughput: the earliest next accepted start is at edge k+W+2.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queuing, and no change to the in-flight operand or result.
REQ-020 bcd SHALL hold the last completed result until the next completion, including while a new conversion runs.
REQ-021 busy = (state != IDLE); done = (state == DONE); both SHALL be registered-state decodes and glitch-free.
REQ-022 Every nibble of bcd SHALL be in 0..9 for any bin in 0..2^W-1; no overflow is possible at legal D.
REQ-023 Add-3 correction SHALL be 4 bits wide per digit; carries never cross digit boundaries.

Reset
REQ-024 rst=1 SHALL immediately, without a clock, force state=IDLE, busy=0, done=0, bcd=0, shift register=0, counter=0.
REQ-025 Reset mid-operation SHALL abandon the conversion; no done pulse follows; bcd reads 0.
REQ-026 The first start after reset release SHALL be accepted on the first rising edge where rst=0 and start=1.

Structure
REQ-027 A shared package bin2bcd_pkg SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default W and D constants.
REQ-028 The per-digit correction SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out: in>=5 ? in+3 : in), instantiated D times via generate.
REQ-029 The top level SHALL contain the FSM, counter, shift register and output register only; target 120-250 lines of RTL.

Verification
REQ-030 Reset, then start with bin=16'd0 -> done after 16 cycles, bcd=20'h00000, busy high for 17 cycles.
REQ-031 bin=16'd65535 -> bcd=20'h65535; bin=16'd9999 -> bcd=20'h09999; bin=16'd49 -> bcd=20'h00049.
REQ-032 Start with bin=1234, pulse start with bin=777 at cycle 5 -> single done, bcd=20'h01234, no second done.
REQ-033 Assert rst at cycle 8 of a conversion of 5000 -> busy=0, done=0, bcd=0 immediately, and no done thereafter.
REQ-034 Back-to-back, start held high: 100 then 200 -> done pulses 18 cycles apart, bcd 20'h00100 then 20'h00200.
REQ-035 Exhaustive sweep of bin=0..65535 against a reference model -> every result matches and all nibbles are <= 9.
